// File: rtl/regfile_sb.sv
// Multi-port integer register file with dual writeback, pending scoreboard
// and a post-reset clear sequencer that zeroes the storage array.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic                  cpu_clk_50M,
   input  logic                  cpu_rst_n,
   input  logic                  we0,
   input  logic [ADDR_W-1:0]     wa0,
   input  logic [DATA_W-1:0]     wd0,
   input  logic                  we1,
   input  logic [ADDR_W-1:0]     wa1,
   input  logic [DATA_W-1:0]     wd1,
   input  logic [NRD-1:0]        re,
   input  logic [NRD*ADDR_W-1:0] ra,
   output logic [NRD*DATA_W-1:0] rd,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_wa,
   input  logic                  flush,
   output logic                  ready
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] clr_nxt;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [DEPTH-1:0]  pend_nxt;
   logic              run;

   assign run   = (state == RUN);
   assign ready = run;

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         pend    <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_nxt;
         pend    <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_cnt;
      unique case (state)
         CLEAR: begin
            clr_nxt = clr_cnt + 1'b1;
            if (clr_cnt == '1)
               state_nxt = RUN;
         end
         RUN: ;
      endcase
   end

   // A new producer's set wins over a retiring producer's clear
   always_comb begin
      pend_nxt = pend;
      if (run) begin
         if (flush) begin
            pend_nxt = '0;
         end else begin
            for (int i = 1; i < DEPTH; i++) begin
               if (iss_valid && iss_wa == ADDR_W'(i))
                  pend_nxt[i] = 1'b1;
               else if ((we0 && wa0 == ADDR_W'(i)) ||
                        (we1 && wa1 == ADDR_W'(i)))
                  pend_nxt[i] = 1'b0;
            end
         end
      end
      pend_nxt[0] = 1'b0;
   end

   // Storage has no reset; the sequencer zeroes it one entry per cycle
   always_ff @(posedge cpu_clk_50M) begin
      if (!run) begin
         regs[clr_cnt] <= '0;
      end else begin
         if (we0 && wa0 != '0)
            regs[wa0] <= wd0;
         if (we1 && wa1 != '0)
            regs[wa1] <= wd1;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              hit1;
      logic              hit0;
      logic [DATA_W-1:0] data;

      assign a    = ra[k*ADDR_W +: ADDR_W];
      assign hit1 = (BYPASS != 0) && we1 && (wa1 == a);
      assign hit0 = (BYPASS != 0) && we0 && (wa0 == a) && !hit1;

      always_comb begin
         data = '0;
         if (run && re[k] && a != '0) begin
            unique case (1'b1)
               hit1:    data = wd1;
               hit0:    data = wd0;
               default: data = regs[a];
            endcase
         end
      end

      assign rd[k*DATA_W +: DATA_W] = data;
      assign rd_busy[k] = run && re[k] && (a != '0) && pend[a] &&
                          !(hit1 || hit0);
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb, bypassing and
// non-bypassing instances against one behavioural model.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic        we0;
   logic [4:0]  wa0;
   logic [31:0] wd0;
   logic        we1;
   logic [4:0]  wa1;
   logic [31:0] wd1;
   logic [1:0]  re;
   logic [9:0]  ra;
   logic [63:0] rd;
   logic [63:0] rd_nb;
   logic [1:0]  busy;
   logic [1:0]  busy_nb;
   logic        iss_valid;
   logic [4:0]  iss_wa;
   logic        flush;
   logic        ready;
   logic        ready_nb;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          m_run;
   int          m_cnt;

   regfile_sb u_dut (
      .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .re(re), .ra(ra), .rd(rd), .rd_busy(busy),
      .iss_valid(iss_valid), .iss_wa(iss_wa),
      .flush(flush), .ready(ready)
   );

   regfile_sb #(.BYPASS(0)) u_nb (
      .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .re(re), .ra(ra), .rd(rd_nb), .rd_busy(busy_nb),
      .iss_valid(iss_valid), .iss_wa(iss_wa),
      .flush(flush), .ready(ready_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic m_reset();
      m_run = 0;
      m_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 0;
      end
   endtask

   task automatic m_clock();
      if (!rst_n) return;
      if (!m_run) begin
         m_cnt++;
         if (m_cnt == 32) m_run = 1;
         return;
      end
      for (int i = 1; i < 32; i++) begin
         if (flush)
            m_pend[i] = 0;
         else if (iss_valid && iss_wa == 5'(i))
            m_pend[i] = 1;
         else if ((we0 && wa0 == 5'(i)) || (we1 && wa1 == 5'(i)))
            m_pend[i] = 0;
      end
      if (we0 && wa0 != 0) m_regs[wa0] = wd0;
      if (we1 && wa1 != 0) m_regs[wa1] = wd1;
   endtask

   function automatic logic [31:0] exp_rd(int k, bit byp);
      logic [4:0] a;
      a = ra[k*5 +: 5];
      if (!m_run || !re[k] || a == 0) return '0;
      if (byp && we1 && wa1 == a) return wd1;
      if (byp && we0 && wa0 == a) return wd0;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(int k, bit byp);
      logic [4:0] a;
      bit hit;
      a = ra[k*5 +: 5];
      hit = byp && ((we1 && wa1 == a) || (we0 && wa0 == a));
      return m_run && re[k] && a != 0 && m_pend[a] && !hit;
   endfunction

   task automatic tick();
      m_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 0; wa0 = 0; wd0 = 0;
      we1 = 0; wa1 = 0; wd1 = 0;
      re = 0; ra = 0;
      iss_valid = 0; iss_wa = 0; flush = 0;
   endtask

   task automatic set_rd(int k, logic [4:0] a);
      re[k] = 1'b1;
      ra[k*5 +: 5] = a;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready got %b want 0", ready);
      end
      rst_n = 1;
      we0 = 1; wa0 = 3; wd0 = 32'hDEAD;
      set_rd(0, 3);
      #1;
      n_cmp++;
      if (rd[31:0] !== 32'h0 || busy !== 2'b00) begin
         n_err++;
         $display("FAIL clear_rd got %h/%b want 0/00", rd[31:0], busy);
      end
      for (int i = 0; i <= 32; i++) begin
         n_cmp++;
         if (ready !== (i == 32) || ready_nb !== (i == 32)) begin
            n_err++;
            $display("FAIL clear_len cyc %0d got %b want %b",
                     i, ready, (i == 32));
         end
         if (i < 32) tick();
      end
      idle();
      for (int r = 1; r < 32; r++) begin
         set_rd(r % 2, 5'(r));
         #1;
         n_cmp++;
         if (rd[(r%2)*32 +: 32] !== 32'h0) begin
            n_err++;
            $display("FAIL clear_zero r%0d got %h want 0",
                     r, rd[(r%2)*32 +: 32]);
         end
         re = 0;
      end
   endtask

   task automatic test_bypass();
      idle();
      we0 = 1; wa0 = 5; wd0 = 32'h1234;
      set_rd(0, 5);
      #1;
      n_cmp++;
      if (rd[31:0] !== 32'h1234 || rd_nb[31:0] !== exp_rd(0, 0)) begin
         n_err++;
         $display("FAIL bypass_same got %h/%h want 1234/%h",
                  rd[31:0], rd_nb[31:0], exp_rd(0, 0));
      end
      tick();
      we0 = 0;
      #1;
      n_cmp++;
      if (rd[31:0] !== 32'h1234 || rd_nb[31:0] !== 32'h1234) begin
         n_err++;
         $display("FAIL bypass_next got %h/%h want 1234/1234",
                  rd[31:0], rd_nb[31:0]);
      end
   endtask

   task automatic test_collision();
      idle();
      we0 = 1; wa0 = 7; wd0 = 1;
      we1 = 1; wa1 = 7; wd1 = 2;
      tick();
      idle();
      set_rd(0, 7);
      #1;
      n_cmp++;
      if (rd[31:0] !== 32'd2 || rd_nb[31:0] !== 32'd2) begin
         n_err++;
         $display("FAIL collide got %h/%h want 2", rd[31:0], rd_nb[31:0]);
      end
      we1 = 1; wa1 = 0; wd1 = 32'hFFFF;
      set_rd(1, 0);
      #1;
      tick();
      idle();
      set_rd(1, 0);
      #1;
      n_cmp++;
      if (rd[63:32] !== 32'h0 || rd_nb[63:32] !== 32'h0) begin
         n_err++;
         $display("FAIL r0 got %h/%h want 0", rd[63:32], rd_nb[63:32]);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      iss_valid = 1; iss_wa = 9;
      tick();
      idle();
      set_rd(1, 9);
      #1;
      n_cmp++;
      if (busy[1] !== 1'b1 || busy_nb[1] !== 1'b1) begin
         n_err++;
         $display("FAIL sb_set got %b/%b want 1/1", busy[1], busy_nb[1]);
      end
      we1 = 1; wa1 = 9; wd1 = 32'h99;
      #1;
      n_cmp++;
      if (busy[1] !== 1'b0 || busy_nb[1] !== exp_busy(1, 0)) begin
         n_err++;
         $display("FAIL sb_byp got %b/%b want 0/%b",
                  busy[1], busy_nb[1], exp_busy(1, 0));
      end
      tick();
      we1 = 0;
      #1;
      n_cmp++;
      if (busy[1] !== 1'b0 || busy_nb[1] !== 1'b0) begin
         n_err++;
         $display("FAIL sb_clr got %b/%b want 0/0", busy[1], busy_nb[1]);
      end
      iss_valid = 1; iss_wa = 9;
      we0 = 1; wa0 = 9; wd0 = 32'h77;
      tick();
      idle();
      set_rd(1, 9);
      #1;
      n_cmp++;
      if (busy[1] !== 1'b1 || busy_nb[1] !== 1'b1) begin
         n_err++;
         $display("FAIL sb_prio got %b/%b want 1/1", busy[1], busy_nb[1]);
      end
      we0 = 1; wa0 = 9; wd0 = 32'h78;
      tick();
      idle();
   endtask

   task automatic test_flush();
      idle();
      iss_valid = 1; iss_wa = 4;
      tick();
      iss_wa = 6;
      tick();
      idle();
      set_rd(0, 4);
      set_rd(1, 6);
      #1;
      n_cmp++;
      if (busy !== 2'b11) begin
         n_err++;
         $display("FAIL flush_pre got %b want 11", busy);
      end
      re = 0;
      flush = 1; iss_valid = 1; iss_wa = 4;
      tick();
      idle();
      set_rd(0, 4);
      set_rd(1, 6);
      #1;
      n_cmp++;
      if (busy !== 2'b00 || busy_nb !== 2'b00) begin
         n_err++;
         $display("FAIL flush got %b/%b want 00/00", busy, busy_nb);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         we0 = 1'($urandom_range(0, 1));
         we1 = 1'($urandom_range(0, 1));
         wa0 = 5'($urandom_range(0, 7));
         wa1 = 5'($urandom_range(0, 7));
         wd0 = $urandom;
         wd1 = $urandom;
         re  = 2'($urandom);
         ra  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_wa = 5'($urandom_range(0, 7));
         flush = ($urandom_range(0, 15) == 0);
         #1;
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rd[k*32 +: 32] !== exp_rd(k, 1) ||
                rd_nb[k*32 +: 32] !== exp_rd(k, 0) ||
                busy[k] !== exp_busy(k, 1) ||
                busy_nb[k] !== exp_busy(k, 0)) begin
               n_err++;
               $display("FAIL rand c%0d p%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                        c, k, rd[k*32 +: 32], rd_nb[k*32 +: 32],
                        busy[k], busy_nb[k], exp_rd(k, 1), exp_rd(k, 0),
                        exp_busy(k, 1), exp_busy(k, 0));
            end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_midrun_reset();
      idle();
      we0 = 1; wa0 = 10; wd0 = 32'hA5A5;
      iss_valid = 1; iss_wa = 12;
      tick();
      idle();
      set_rd(0, 10);
      #1;
      n_cmp++;
      if (rd[31:0] !== 32'hA5A5) begin
         n_err++;
         $display("FAIL mid_pre got %h want a5a5", rd[31:0]);
      end
      rst_n = 0;
      m_reset();
      #1;
      n_cmp++;
      if (ready !== 1'b0 || ready_nb !== 1'b0) begin
         n_err++;
         $display("FAIL mid_drop got %b/%b want 0", ready, ready_nb);
      end
      #2;
      rst_n = 1;
      for (int i = 0; i <= 32; i++) begin
         n_cmp++;
         if (ready !== (i == 32)) begin
            n_err++;
            $display("FAIL mid_clear cyc %0d got %b want %b",
                     i, ready, (i == 32));
         end
         if (i < 32) tick();
      end
      set_rd(0, 10);
      #1;
      n_cmp++;
      if (rd[31:0] !== 32'h0 || rd_nb[31:0] !== 32'h0) begin
         n_err++;
         $display("FAIL mid_r10 got %h/%h want 0", rd[31:0], rd_nb[31:0]);
      end
      for (int r = 1; r < 32; r++) begin
         set_rd(1, 5'(r));
         #1;
         n_cmp++;
         if (busy[1] !== exp_busy(1, 1) || busy_nb[1] !== 1'b0) begin
            n_err++;
            $display("FAIL mid_pend r%0d got %b/%b want 0",
                     r, busy[1], busy_nb[1]);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_collision();
      test_scoreboard();
      test_flush();
      test_random();
      test_midrun_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-write, dual-read integer register file in the MiniMIPS32 core.
- Adds a configurable number of read ports and a second write port, for dual writeback (ALU plus memory).
- Adds a per-register pending scoreboard so the ID stage can detect load-use hazards without a separate unit.
- Adds a post-reset clear sequencer, so the storage array needs no reset network.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries
NRD, 2, number of read ports
BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return array contents only

Ports:
cpu_clk_50M  in  1  core clock; all state updates on its rising edge
cpu_rst_n  in  1  reset, asynchronous, active-low
we0  in  1  write port 0 enable
wa0  in  ADDR_W  write port 0 address
wd0  in  DATA_W  write port 0 data
we1  in  1  write port 1 enable; higher priority than port 0
wa1  in  ADDR_W  write port 1 address
wd1  in  DATA_W  write port 1 data
re  in  NRD  per-port read enable
ra  in  NRD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rd  out  NRD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W]
rd_busy  out  NRD  per-port pending flag: the register read has an outstanding producer
iss_valid  in  1  issue of an instruction that will write iss_wa
iss_wa  in  ADDR_W  destination register of the issued instruction
flush  in  1  clear all pending bits (pipeline flush)
ready  out  1  clear sequence complete; register file usable

Behaviour:
- State machine has two states: CLEAR and RUN. An ADDR_W-bit clear counter clr_cnt drives the sequence.
- Asynchronous reset (cpu_rst_n=0):
  - state=CLEAR, clr_cnt=0, all pend bits=0, ready=0.
  - This applies at any time, including mid-RUN or mid-CLEAR; the sequence always restarts from entry 0.
- CLEAR state:
  - Each cycle: regs[clr_cnt] <= 0, then clr_cnt increments.
  - When clr_cnt==DEPTH-1: write that entry, then state=RUN. ready=1 from the next cycle, i.e. DEPTH cycles after reset release.
  - we0/we1/iss_valid/flush are ignored.
  - rd = 0 and rd_busy = 0 on all ports.
- RUN state, writes:
  - Port p writes regs[wa_p] <= wd_p when we_p=1 and wa_p!=0.
  - Both ports to the same address in one cycle: port 1 value is stored.
  - Register 0 is never written and always reads 0.
- RUN state, reads (combinational, per port k):
  - ra_k==0 or re_k==0 -> rd_k=0.
  - Else if BYPASS and we1 && wa1==ra_k -> wd1.
  - Else if BYPASS and we0 && wa0==ra_k -> wd0.
  - Else -> regs[ra_k].
- Scoreboard (pend[0..DEPTH-1], pend[0] tied 0). Per entry, per cycle, in priority order:
  1. flush -> pend=0 for all entries.
  2. iss_valid && iss_wa==i && i!=0 -> pend[i]=1. Set wins over a same-cycle clear, because a new producer supersedes the retiring one.
  3. (we0 && wa0==i) or (we1 && wa1==i) -> pend[i]=0.
- rd_busy_k = re_k && ra_k!=0 && pend[ra_k] && !bypass_hit_k.
  - bypass_hit_k is the same-cycle forwarding condition above; it is always 0 when BYPASS=0.
  - rd_busy reflects registered pend, not this cycle's iss_valid.
- Latency:
  - Read: 0 cycles.
  - Write visible through the array: next cycle.
  - pend update visible: next cycle.

Test Plan:
- Reset clear: release cpu_rst_n, hold we0=1 wa0=3 wd0=32'hDEAD -> ready=0 for exactly 32 cycles then 1; read r3 gives 0 (write during CLEAR ignored); r1..r31 read 0.
- Write/read with bypass: RUN, we0=1 wa0=5 wd0=32'h1234, re[0]=1 ra0=5 in the same cycle -> rd0=32'h1234 that cycle; with BYPASS=0 -> rd0=0 that cycle, 32'h1234 the next cycle.
- Dual-write collision and r0: we0=1 wa0=7 wd0=1 and we1=1 wa1=7 wd1=2 -> r7 reads 2; we1=1 wa1=0 wd1=32'hFFFF -> r0 still reads 0.
- Scoreboard:
  - iss_valid=1 iss_wa=9 -> next cycle ra1=9 re[1]=1 gives rd_busy[1]=1.
  - we1 wa1=9 -> rd_busy[1]=0 in that cycle (bypass) and after.
  - iss_valid wa=9 together with we0 wa0=9 in one cycle -> pend[9] stays 1.
- Flush: set pend on r4 and r6, assert flush together with iss_valid iss_wa=4 -> next cycle rd_busy=0 for both r4 and r6.
- Mid-run reset: write r10=32'hA5A5, pulse cpu_rst_n low for 3 ns between clock edges -> ready drops immediately, 32 cycles of CLEAR follow, r10 reads 0, all pending bits clear.
